bcd_addsub_seq: RTL

Parametrised, sequential multi-digit BCD adder/subtractor for the calculator datapath. It processes one BCD digit per clock, least significant digit first, and reports sum or signed difference in BCD. It sits between the operand entry registers and the seven-segment display formatter, and replaces fixed-width two-digit combinational addition.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_adder.sv | 22 ++
 rtl/bcd_addsub_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD adder/subtractor:
// FSM state encoding, largest legal BCD digit and a digit-validity helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic digit_valid(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One-digit BCD adder with decimal correction; purely combinational.
// Inputs are assumed to be valid BCD digits, so the raw sum stays within 0..19.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);

  logic [4:0] s;

  always_comb begin
    s    = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    cout = s > {1'b0, BCD_MAX};
    // Subtracting 10 modulo 16 gives the corrected digit for s in 10..19.
    digit = cout ? (s[3:0] - 4'd10) : s[3:0];
  end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Serial BCD add/subtract, one digit per clock, LSD first; A<B subtraction takes a second ten's-complement pass.
// Latency DIGITS (or 2*DIGITS when A<B) cycles from accepted start to done; start is ignored while not IDLE.
module bcd_addsub_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   op_a,
  input  logic [4*DIGITS-1:0]   op_b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  carry,
  output logic                  neg,
  output logic                  invalid
);
  import bcd_pkg::*;

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t        state;
  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic          sub_r;
  logic          c;
  logic [IW-1:0] idx;
  logic          last;
  logic          ops_ok;
  logic [3:0]    add_a;
  logic [3:0]    add_b;
  logic [3:0]    sum_d;
  logic          cout;

  assign last = (idx == IW'(DIGITS - 1));

  always_comb begin
    ops_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_valid(op_a[4*i +: 4]) || !digit_valid(op_b[4*i +: 4]))
        ops_ok = 1'b0;
    end
  end

  // The single digit adder serves both passes: A + (B or 9-B) in CALC, (9-r) + carry in NEG.
  always_comb begin
    add_a = a_sr[3:0];
    add_b = sub_r ? (BCD_MAX - b_sr[3:0]) : b_sr[3:0];
    if (state == NEG) begin
      add_a = BCD_MAX - result[3:0];
      add_b = 4'd0;
    end
  end

  bcd_digit_adder u_digit_adder (
    .a     (add_a),
    .b     (add_b),
    .cin   (c),
    .digit (sum_d),
    .cout  (cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      sub_r   <= 1'b0;
      c       <= 1'b0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      neg     <= 1'b0;
      invalid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= op_a;
            b_sr  <= op_b;
            sub_r <= sub;
            c     <= sub;
            idx   <= '0;
            carry <= 1'b0;
            neg   <= 1'b0;
            if (!ops_ok) begin
              result  <= '0;
              invalid <= 1'b1;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              invalid <= 1'b0;
              busy    <= 1'b1;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          // Operands shift down one digit; each new result digit enters at the top.
          a_sr   <= a_sr >> 4;
          b_sr   <= b_sr >> 4;
          result <= (result >> 4) | (W'(sum_d) << (W - 4));
          c      <= cout;
          if (last) begin
            idx <= '0;
            if (!sub_r || cout) begin
              carry <= !sub_r && cout;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              c     <= 1'b1;
              state <= NEG;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        NEG: begin
          result <= (result >> 4) | (W'(sum_d) << (W - 4));
          c      <= cout;
          if (last) begin
            idx   <= '0;
            neg   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
